// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard / stall controller.
package hazard_pkg;

    // Controller FSM states; encoding is visible on the state_o debug port.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    // Register 0 is hard-wired to zero, so it can never carry a data hazard.
    localparam logic [3:0] REG_ZERO = 4'h0;

    // Instruction word the pipeline registers load when they are flushed.
    localparam logic [15:0] NOP_INST = 16'h0000;

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count qualifying cycles, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && !(&count)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use stalls, taken-branch squash window
// and whole-pipeline freeze while data memory is busy, plus perf counters.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       inst_ifid_rs,
    input  logic [3:0]       inst_ifid_rt,
    input  logic [3:0]       inst_ifid_rd,
    input  logic             ifid_uses_rs,
    input  logic             ifid_uses_rt,
    input  logic             ifid_is_store,
    input  logic [3:0]       rf_waddr_idex,
    input  logic             rf_wen_idex,
    input  logic             mem2reg_idex,
    input  logic             branch_taken_exmem,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_wen,
    output logic             ifid_wen,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_wen,
    output logic             memwb_wen,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Remaining squash cycles after the one spent entering the window.
    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
    // A single-cycle window is fully handled in the branch cycle itself.
    localparam state_t BRANCH_NEXT = (FLUSH_CYCLES > 1) ? FLUSH : RUN;

    state_t     state;
    state_t     state_next;
    logic [2:0] flush_left;
    logic [2:0] flush_left_next;
    logic       load_use;
    logic       mem_stall;

    assign mem_stall = dmem_req && !dmem_ready;
    assign state_o   = state;

    // A load in ID/EX whose result is needed by the instruction in IF/ID.
    always_comb begin
        load_use = rf_wen_idex && mem2reg_idex && (rf_waddr_idex != REG_ZERO) &&
                   ((ifid_uses_rs  && (inst_ifid_rs == rf_waddr_idex)) ||
                    (ifid_uses_rt  && (inst_ifid_rt == rf_waddr_idex)) ||
                    (ifid_is_store && (inst_ifid_rd == rf_waddr_idex)));
    end

    // State and squash-window counter; reset drops any pending flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            flush_left <= '0;
        end else begin
            state      <= state_next;
            flush_left <= flush_left_next;
        end
    end

    // Mealy outputs and next state; memory freeze beats branch beats load-use.
    always_comb begin
        pc_wen          = 1'b1;
        ifid_wen        = 1'b1;
        ifid_flush      = 1'b0;
        idex_flush      = 1'b0;
        exmem_wen       = 1'b1;
        memwb_wen       = 1'b1;
        state_next      = state;
        flush_left_next = flush_left;
        if (rst_n) begin
            if (state == FLUSH && !mem_stall) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                if (branch_taken_exmem) begin
                    flush_left_next = FLUSH_RELOAD;
                    state_next      = BRANCH_NEXT;
                end else if (flush_left <= 3'd1) begin
                    flush_left_next = '0;
                    state_next      = RUN;
                end else begin
                    flush_left_next = flush_left - 3'd1;
                end
            end else if (mem_stall || (state == MEM_WAIT && !dmem_ready)) begin
                pc_wen     = 1'b0;
                ifid_wen   = 1'b0;
                exmem_wen  = 1'b0;
                memwb_wen  = 1'b0;
                state_next = MEM_WAIT;
            end else begin
                state_next = (state == MEM_WAIT && flush_left != 3'd0) ? FLUSH : RUN;
                if (branch_taken_exmem) begin
                    ifid_flush      = 1'b1;
                    idex_flush      = 1'b1;
                    flush_left_next = FLUSH_RELOAD;
                    state_next      = BRANCH_NEXT;
                end else if (load_use) begin
                    pc_wen     = 1'b0;
                    ifid_wen   = 1'b0;
                    idex_flush = 1'b1;
                end
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (!pc_wen),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ifid_flush),
        .count (flush_cnt)
    );

endmodule
